heart_rate_rgb_indicator: RTL
=============================

# heart_rate_rgb_indicator

Downstream stage of the ADC-to-heart-rate converter. It classifies each live heart-rate value against the min/max thresholds and drives the board's red/green/blue status LEDs. It debounces class changes over consecutive beats, detects loss of signal, and holds a sticky alarm for the operator.

## Interface
Parameters:
- CONFIRM_BEATS, 3: consecutive beats of a new class required to change state. Legal range 1..15.
- BLINK_HALF, 25_000_000: clock cycles per blink half-period (0.5 s at 50 MHz). Minimum 1.
- TIMEOUT_CYCLES, 150_000_000: cycles without a beat before NO_SIGNAL (3 s at 50 MHz). Minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- measuring  in  1  measurement window active.
- beat_valid  in  1  one-cycle strobe: heart_beat_val_live holds a new beat value.
- heart_beat_val_live  in  8  latest heart rate in bpm.
- min_heart_threshold  in  8  lower limit in bpm, inclusive-normal.
- max_heart_threshold  in  8  upper limit in bpm, inclusive-normal.
- alarm_clear  in  1  operator acknowledge, level-sampled.
- led_red  out  1  red LED.
- led_green  out  1  green LED.
- led_blue  out  1  blue LED.
- status  out  3  current state: 0 IDLE, 1 ACQUIRE, 2 NORMAL, 3 LOW, 4 HIGH, 5 NO_SIGNAL.
- alarm_latched  out  1  sticky alarm flag.
- class_changes  out  8  saturating count of NORMAL/LOW/HIGH transitions.

## Operation
- Beat class, evaluated on beat_valid:
  - LOW if val < min.
  - else HIGH if val > max.
  - else NORMAL.
  - LOW has priority when min > max.
- Candidate tracker (cand_class, cand_cnt 4-bit), updated on each accepted beat:
  - Class equals the current state's class: cand_cnt cleared to 0.
  - Else, class equals cand_class: cand_cnt increments.
  - Else: cand_class = class, cand_cnt = 1.
  - When the updated count equals CONFIRM_BEATS, state moves to that class and cand_cnt is cleared.
- State transitions:
  - IDLE: when measuring=1, go to ACQUIRE. Beats are ignored.
  - ACQUIRE / NORMAL / LOW / HIGH: beats are processed by the tracker. On timeout, go to NO_SIGNAL.
  - NO_SIGNAL: a beat goes to ACQUIRE and is processed as in ACQUIRE (count 1). With CONFIRM_BEATS=1 the beat goes directly to its class.
  - Any state with measuring=0: go to IDLE. This has priority over beat_valid and timeout. The tracker and timeout counter clear; alarm_latched and class_changes are kept.
- Timeout counter:
  - Clears on beat_valid, on entry to ACQUIRE, and in IDLE/NO_SIGNAL.
  - Increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no beat_valid that cycle, state goes to NO_SIGNAL.
- LED decode (combinational from the state register and the blink_phase register):
  - IDLE: blue on.
  - ACQUIRE: blue = blink_phase.
  - NORMAL: green on.
  - LOW: red = blink_phase.
  - HIGH: red on.
  - NO_SIGNAL: red = blue = blink_phase.
  - All unlisted LEDs are 0.
- Blink generator:
  - Counter counts 0..BLINK_HALF-1; blink_phase toggles on wrap.
  - On every state change, the counter clears and blink_phase is set to 1.
- alarm_latched:
  - Set on entry to LOW, HIGH or NO_SIGNAL.
  - Cleared by alarm_clear only while the state is IDLE, ACQUIRE or NORMAL.
  - Set wins over a simultaneous clear.
- class_changes: increments on a transition between two different states of {NORMAL, LOW, HIGH}; saturates at 255.

## Timing
- Reset values:
  - status=0 (IDLE), led_blue=1, led_red=0, led_green=0.
  - alarm_latched=0, class_changes=0, blink_phase=1.
  - All counters 0.
- The state register updates on the clock edge that samples the confirming beat_valid. status and LEDs change in the following cycle (latency 1).
- Measuring fall: IDLE visible 1 cycle after measuring=0 is sampled.
- Timeout: NO_SIGNAL becomes visible exactly TIMEOUT_CYCLES cycles after the last beat_valid (or after ACQUIRE entry).
- Blink: first toggle occurs BLINK_HALF cycles after state entry; period is 2*BLINK_HALF.
- Reset asserted at any time forces reset values immediately (asynchronous), including mid-blink and mid-candidate.

## Test plan
Bench parameters: CONFIRM_BEATS=3, BLINK_HALF=4, TIMEOUT_CYCLES=50, min=60, max=160.
1. Apply reset, then release → status=0, led_blue=1, red=green=0, alarm_latched=0, class_changes=0.
2. Set measuring=1 → status=1 next cycle, led_blue toggles every 4 cycles. Send beats 75, 75 → status stays 1. Send a third 75 → status=2 and led_green=1 one cycle later.
3. From NORMAL, send beats 50, 50, 170, 50, 50 → status stays 2. Send another 50 → status=3, led_red blinking (on 4, off 4), alarm_latched=1, class_changes=1.
4. From LOW, send 3 beats of 200 → status=4, led_red=1 solid, class_changes=2. Then send no beats for 50 cycles → status=5, red and blue blink together. Send beat 100 → status=1.
5. Assert alarm_clear while status=4 → alarm_latched stays 1. Reach NORMAL, then assert alarm_clear → alarm_latched=0 next cycle. Assert alarm_clear in the same cycle as LOW entry → alarm_latched=1.
6. Drop measuring after 2 candidate beats → status=0 next cycle. Raise measuring and send 1 beat → still ACQUIRE, showing the candidate count was cleared. Assert reset mid-blink → outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/heart_rate_rgb_indicator_if.sv
// Signal bundle between the heart-rate converter and the RGB status indicator.
// The master side drives the beat stream and thresholds; the slave (indicator) drives LEDs and status.
interface heart_rate_rgb_indicator_if;
    logic       measuring;
    logic       beat_valid;
    logic [7:0] heart_beat_val_live;
    logic [7:0] min_heart_threshold;
    logic [7:0] max_heart_threshold;
    logic       alarm_clear;
    logic       led_red;
    logic       led_green;
    logic       led_blue;
    logic [2:0] status;
    logic       alarm_latched;
    logic [7:0] class_changes;

    modport master (
        output measuring, beat_valid, heart_beat_val_live,
               min_heart_threshold, max_heart_threshold, alarm_clear,
        input  led_red, led_green, led_blue, status, alarm_latched, class_changes
    );

    modport slave (
        input  measuring, beat_valid, heart_beat_val_live,
               min_heart_threshold, max_heart_threshold, alarm_clear,
        output led_red, led_green, led_blue, status, alarm_latched, class_changes
    );
endinterface

// File: rtl/heart_rate_rgb_indicator.sv
// Classifies live heart-rate beats against thresholds, debounces class changes,
// detects loss of signal and drives RGB status LEDs plus a sticky operator alarm.
module heart_rate_rgb_indicator #(
    parameter int unsigned CONFIRM_BEATS  = 3,
    parameter int unsigned BLINK_HALF     = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 150_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    heart_rate_rgb_indicator_if.slave  hr
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ACQUIRE   = 3'd1;
    localparam logic [2:0] S_NORMAL    = 3'd2;
    localparam logic [2:0] S_LOW       = 3'd3;
    localparam logic [2:0] S_HIGH      = 3'd4;
    localparam logic [2:0] S_NO_SIGNAL = 3'd5;

    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    CONFIRM    = 4'(CONFIRM_BEATS);

    logic [2:0]    state_q, state_d;
    logic [2:0]    cand_class_q, cand_class_d;
    logic [3:0]    cand_cnt_q, cand_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          alarm_q, alarm_d;
    logic [7:0]    changes_q, changes_d;

    logic [2:0] beat_class;
    logic [2:0] trk_class;
    logic [3:0] trk_cnt;
    logic       trk_confirm;
    logic       state_change;
    logic       led_r, led_g, led_b;

    function automatic logic is_class_state(input logic [2:0] s);
        return (s == S_NORMAL) || (s == S_LOW) || (s == S_HIGH);
    endfunction

    function automatic logic is_alarm_state(input logic [2:0] s);
        return (s == S_LOW) || (s == S_HIGH) || (s == S_NO_SIGNAL);
    endfunction

    // LOW is tested first so it wins when min > max.
    always_comb begin
        if (hr.heart_beat_val_live < hr.min_heart_threshold) begin
            beat_class = S_LOW;
        end else if (hr.heart_beat_val_live > hr.max_heart_threshold) begin
            beat_class = S_HIGH;
        end else begin
            beat_class = S_NORMAL;
        end
    end

    always_comb begin
        trk_class = cand_class_q;
        trk_cnt   = cand_cnt_q;
        if (beat_class == state_q) begin
            trk_cnt = '0;
        end else if (beat_class == cand_class_q) begin
            trk_cnt = cand_cnt_q + 4'd1;
        end else begin
            trk_class = beat_class;
            trk_cnt   = 4'd1;
        end
        trk_confirm = (trk_cnt == CONFIRM);
    end

    always_comb begin
        state_d      = state_q;
        cand_class_d = cand_class_q;
        cand_cnt_d   = cand_cnt_q;
        to_cnt_d     = to_cnt_q;
        if (!hr.measuring) begin
            state_d      = S_IDLE;
            cand_class_d = S_IDLE;
            cand_cnt_d   = '0;
            to_cnt_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_ACQUIRE;
                    to_cnt_d = '0;
                end
                S_NO_SIGNAL: begin
                    to_cnt_d = '0;
                    if (hr.beat_valid) begin
                        // Recovery beat starts a fresh candidate run of length one.
                        cand_class_d = beat_class;
                        if (CONFIRM == 4'd1) begin
                            state_d    = beat_class;
                            cand_cnt_d = '0;
                        end else begin
                            state_d    = S_ACQUIRE;
                            cand_cnt_d = 4'd1;
                        end
                    end
                end
                S_ACQUIRE, S_NORMAL, S_LOW, S_HIGH: begin
                    if (hr.beat_valid) begin
                        to_cnt_d     = '0;
                        cand_class_d = trk_class;
                        if (trk_confirm) begin
                            state_d    = trk_class;
                            cand_cnt_d = '0;
                        end else begin
                            cand_cnt_d = trk_cnt;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d  = S_NO_SIGNAL;
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    cand_class_d = S_IDLE;
                    cand_cnt_d   = '0;
                    to_cnt_d     = '0;
                end
            endcase
        end
    end

    assign state_change = (state_d != state_q);

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (state_change) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // Set is applied after clear so a new alarm entry always wins.
    always_comb begin
        alarm_d = alarm_q;
        if (hr.alarm_clear && (state_q == S_IDLE || state_q == S_ACQUIRE || state_q == S_NORMAL)) begin
            alarm_d = 1'b0;
        end
        if (state_change && is_alarm_state(state_d)) begin
            alarm_d = 1'b1;
        end
    end

    always_comb begin
        changes_d = changes_q;
        if (state_change && is_class_state(state_q) && is_class_state(state_d) && (changes_q != 8'hFF)) begin
            changes_d = changes_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cand_class_q <= S_IDLE;
            cand_cnt_q   <= '0;
            to_cnt_q     <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b1;
            alarm_q      <= 1'b0;
            changes_q    <= '0;
        end else begin
            state_q      <= state_d;
            cand_class_q <= cand_class_d;
            cand_cnt_q   <= cand_cnt_d;
            to_cnt_q     <= to_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            alarm_q      <= alarm_d;
            changes_q    <= changes_d;
        end
    end

    always_comb begin
        led_r = 1'b0;
        led_g = 1'b0;
        led_b = 1'b0;
        case (state_q)
            S_IDLE:      led_b = 1'b1;
            S_ACQUIRE:   led_b = blink_q;
            S_NORMAL:    led_g = 1'b1;
            S_LOW:       led_r = blink_q;
            S_HIGH:      led_r = 1'b1;
            S_NO_SIGNAL: begin
                led_r = blink_q;
                led_b = blink_q;
            end
            default: ;
        endcase
    end

    assign hr.led_red       = led_r;
    assign hr.led_green     = led_g;
    assign hr.led_blue      = led_b;
    assign hr.status        = state_q;
    assign hr.alarm_latched = alarm_q;
    assign hr.class_changes = changes_q;

endmodule
